filter_window_7x7_gen: RTL

Generates the 7x7 pixel neighbourhood consumed by the 7x7 median filter entity from a raster pixel stream. Six line buffers plus a 7x7 shift-register window turn one pixel per cycle into one fully populated 49-pixel kernel per cycle. The kernel is packed exactly as the filter's `xi` input expects. The block sits directly upstream of the median filter in the video filter chain and emits only windows whose 49 pixels are all real image data, with no padding.

---
 rtl/filter_window_7x7_gen.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/filter_window_7x7_gen.sv
// 7x7 neighbourhood generator: six line buffers plus a 7x7 shift window.
// Emits one fully populated kernel per accepted pixel once 7 lines x 7 columns are present.
module filter_window_7x7_gen #(
  parameter int unsigned PIXEL_WIDTH   = 8,
  parameter int unsigned LINE_SIZE_MAX = 1024,
  parameter int unsigned KERNEL_SIZE   = 49
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [PIXEL_WIDTH-1:0]             di,
  input  logic                               de,
  input  logic                               sof,
  input  logic                               eol,
  output logic [PIXEL_WIDTH*KERNEL_SIZE-1:0] xo,
  output logic                               xo_de,
  output logic                               xo_sof,
  output logic                               xo_eol,
  output logic                               err
);

  localparam int unsigned AW = (LINE_SIZE_MAX > 1) ? $clog2(LINE_SIZE_MAX) : 1;
  localparam logic [AW-1:0] ColLast = AW'(LINE_SIZE_MAX - 1);
  localparam logic [AW-1:0] ColSix  = AW'(6);
  localparam logic [2:0]    RowLast = 3'd6;

  logic [PIXEL_WIDTH-1:0] lb_mem [6][LINE_SIZE_MAX];

  logic [AW-1:0] col_q, col_d, col_c;
  logic [2:0]    row_q, row_d, row_c;
  logic          drop_q, drop_d, drop_c;
  logic          err_q, err_d, err_c;
  logic          pend_q, pend_d, pend_c;
  logic          accept, win_ok;

  logic                   s1_vld_q, s1_vld_d;
  logic                   s1_win_q, s1_win_d;
  logic                   s1_sof_q, s1_sof_d;
  logic                   s1_eol_q, s1_eol_d;
  logic [PIXEL_WIDTH-1:0] s1_px_q, s1_px_d;
  logic [PIXEL_WIDTH-1:0] rd_q [6];
  logic [PIXEL_WIDTH-1:0] rd_d [6];

  logic [PIXEL_WIDTH-1:0] win_q [7][7];
  logic [PIXEL_WIDTH-1:0] win_d [7][7];
  logic                   xo_de_q, xo_de_d;
  logic                   xo_sof_q, xo_sof_d;
  logic                   xo_eol_q, xo_eol_d;

  // sof takes effect before the pixel itself is processed; drop marks an overflowed line.
  always_comb begin
    col_c  = col_q;
    row_c  = row_q;
    drop_c = drop_q;
    err_c  = err_q;
    pend_c = pend_q;
    if (de && sof) begin
      col_c  = '0;
      row_c  = '0;
      drop_c = 1'b0;
      err_c  = 1'b0;
      pend_c = 1'b1;
    end
    accept = de && !drop_c;
    win_ok = accept && (row_c == RowLast) && (col_c >= ColSix);

    col_d  = col_q;
    row_d  = row_q;
    drop_d = drop_q;
    err_d  = err_q;
    pend_d = pend_q;
    if (de) begin
      col_d  = col_c;
      row_d  = row_c;
      drop_d = drop_c;
      err_d  = err_c;
      pend_d = pend_c && !win_ok;
      if (eol) begin
        col_d  = '0;
        drop_d = 1'b0;
        if (row_c != RowLast) row_d = row_c + 3'd1;
      end else if (!drop_c) begin
        if (col_c == ColLast) begin
          err_d  = 1'b1;
          drop_d = 1'b1;
        end else begin
          col_d = col_c + AW'(1);
        end
      end
    end
  end

  always_comb begin
    s1_vld_d = accept;
    s1_win_d = win_ok;
    s1_sof_d = win_ok && pend_c;
    s1_eol_d = win_ok && eol;
    s1_px_d  = accept ? di : s1_px_q;
    for (int r = 0; r < 6; r++) begin
      rd_d[r] = accept ? lb_mem[5-r][col_c] : rd_q[r];
    end
  end

  // Window shifts one cycle after the RAM read so the column lines up.
  always_comb begin
    win_d    = win_q;
    xo_de_d  = s1_win_q;
    xo_sof_d = s1_sof_q;
    xo_eol_d = s1_eol_q;
    if (s1_vld_q) begin
      for (int r = 0; r < 7; r++) begin
        for (int c = 0; c < 6; c++) win_d[r][c] = win_q[r][c+1];
        win_d[r][6] = (r == 6) ? s1_px_q : rd_q[r];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      lb_mem[0][col_c] <= di;
      for (int n = 1; n < 6; n++) lb_mem[n][col_c] <= lb_mem[n-1][col_c];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col_q    <= '0;
      row_q    <= '0;
      drop_q   <= 1'b0;
      err_q    <= 1'b0;
      pend_q   <= 1'b0;
      s1_vld_q <= 1'b0;
      s1_win_q <= 1'b0;
      s1_sof_q <= 1'b0;
      s1_eol_q <= 1'b0;
      s1_px_q  <= '0;
      rd_q     <= '{default: '0};
      win_q    <= '{default: '{default: '0}};
      xo_de_q  <= 1'b0;
      xo_sof_q <= 1'b0;
      xo_eol_q <= 1'b0;
    end else begin
      col_q    <= col_d;
      row_q    <= row_d;
      drop_q   <= drop_d;
      err_q    <= err_d;
      pend_q   <= pend_d;
      s1_vld_q <= s1_vld_d;
      s1_win_q <= s1_win_d;
      s1_sof_q <= s1_sof_d;
      s1_eol_q <= s1_eol_d;
      s1_px_q  <= s1_px_d;
      rd_q     <= rd_d;
      win_q    <= win_d;
      xo_de_q  <= xo_de_d;
      xo_sof_q <= xo_sof_d;
      xo_eol_q <= xo_eol_d;
    end
  end

  always_comb begin
    xo = '0;
    for (int r = 0; r < 7; r++) begin
      for (int c = 0; c < 7; c++) xo[(r*7+c)*PIXEL_WIDTH +: PIXEL_WIDTH] = win_q[r][c];
    end
  end

  assign xo_de  = xo_de_q;
  assign xo_sof = xo_sof_q;
  assign xo_eol = xo_eol_q;
  assign err    = err_q;

endmodule
